// File: rtl/hpi_target_model_if.sv
// hpi_target_model_if: HPI control strobes between the host-side HPI master and the OTG target.
//   OTG_ADDR  [1:0] register select (00 DATA, 01 MAILBOX, 10 ADDRESS, 11 STATUS)
//   OTG_RD_N        read strobe, active low
//   OTG_WR_N        write strobe, active low
//   OTG_CS_N        chip select, active low
//   OTG_RST_N       chip soft reset, active low
//   OTG_INT         target interrupt, high while outgoing mailbox full
// OTG_DATA is bidirectional and stays a plain inout port of the target.
interface hpi_target_model_if;
    logic [1:0] OTG_ADDR;
    logic       OTG_RD_N;
    logic       OTG_WR_N;
    logic       OTG_CS_N;
    logic       OTG_RST_N;
    logic       OTG_INT;
    modport master (output OTG_ADDR, OTG_RD_N, OTG_WR_N, OTG_CS_N, OTG_RST_N, input OTG_INT);
    modport slave  (input OTG_ADDR, OTG_RD_N, OTG_WR_N, OTG_CS_N, OTG_RST_N, output OTG_INT);
endinterface

// File: rtl/hpi_target_model.sv
// hpi_target_model: responder end of the 16-bit CY7C67200 HPI bus backed by an on-chip word RAM.
//   Clk            system clock, rising edge
//   Reset_N        asynchronous active-low reset
//   otg            HPI strobes/address/soft reset in, OTG_INT out
//   OTG_DATA       HPI data, driven only during a read access
//   mbx_in_*       host-to-local mailbox word, pending flag and local consume pulse
//   mbx_out_*      local-to-host mailbox word and load pulse (raises OTG_INT)
//   proto_err_cnt  saturating protocol violation count, live only with HPI_PROTO_CHECK_EN
module hpi_target_model #(
    parameter int          DEPTH   = 1024,
    parameter logic [15:0] RST_VAL = 16'h0000
) (
    input  logic              Clk,
    input  logic              Reset_N,
    hpi_target_model_if.slave otg,
    inout  wire  [15:0]       OTG_DATA,
    output logic [15:0]       mbx_in_data,
    output logic              mbx_in_valid,
    input  logic              mbx_in_ack,
    input  logic [15:0]       mbx_out_data,
    input  logic              mbx_out_wr,
    output logic [7:0]        proto_err_cnt
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {A_DATA, A_MBX, A_ADDR, A_STAT} reg_e;
    logic [15:0]   mem [DEPTH];
    logic [15:0]   hpi_addr, rd_q, mbx_out, rd_src;
    logic          ovr, int_q, rd_prev, wr_prev, rd_busy;
    logic          rd_act, wr_act, rd_start, wr_start, rd_end, soft_rst, inc_w, inc_r;
    logic [AW-1:0] idx;
    reg_e          sel, rd_sel;

    assign sel      = reg_e'(otg.OTG_ADDR);
    assign soft_rst = ~otg.OTG_RST_N;
    assign rd_act   = ~otg.OTG_CS_N & ~otg.OTG_RD_N & otg.OTG_WR_N;
    assign wr_act   = ~otg.OTG_CS_N & ~otg.OTG_WR_N & otg.OTG_RD_N;
    assign rd_start = rd_act & ~rd_prev;
    assign wr_start = wr_act & ~wr_prev;
    assign rd_end   = rd_busy & ~rd_act;
    assign idx      = hpi_addr[AW:1];
    assign inc_w    = wr_start & (sel == A_DATA);
    assign inc_r    = rd_end & (rd_sel == A_DATA);
    assign otg.OTG_INT = int_q;
    assign OTG_DATA = rd_act ? rd_q : 'z;
    assign rd_src = sel == A_DATA ? mem[idx] :
                    sel == A_MBX  ? mbx_out  :
                    sel == A_ADDR ? hpi_addr : {ovr, 6'b0, mbx_in_valid, 7'b0, int_q};

    // Previous-strobe flops reset to 1 so a strobe still held across reset is
    // not seen as a fresh start; the aborted access therefore never writes RAM.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            hpi_addr     <= RST_VAL;
            rd_q         <= '0;
            mbx_in_data  <= '0;
            mbx_in_valid <= 1'b0;
            mbx_out      <= '0;
            int_q        <= 1'b0;
            ovr          <= 1'b0;
            rd_prev      <= 1'b1;
            wr_prev      <= 1'b1;
            rd_busy      <= 1'b0;
            rd_sel       <= A_DATA;
        end else if (soft_rst) begin
            hpi_addr     <= RST_VAL;
            rd_q         <= '0;
            mbx_in_data  <= '0;
            mbx_in_valid <= 1'b0;
            mbx_out      <= '0;
            int_q        <= 1'b0;
            ovr          <= 1'b0;
            rd_prev      <= 1'b1;
            wr_prev      <= 1'b1;
            rd_busy      <= 1'b0;
            rd_sel       <= A_DATA;
        end else begin
            rd_prev <= rd_act;
            wr_prev <= wr_act;
            rd_busy <= rd_start | (rd_busy & rd_act);
            if (rd_start) begin
                rd_sel <= sel;
                rd_q   <= rd_src;
            end
            if (wr_start && sel == A_ADDR)
                hpi_addr <= OTG_DATA;
            else
                hpi_addr <= hpi_addr + {13'd0, 2'(inc_w) + 2'(inc_r), 1'b0};
            if (rd_end && rd_sel == A_STAT)
                ovr <= 1'b0;
            if (mbx_in_ack)
                mbx_in_valid <= 1'b0;
            // A host write in the same cycle as a local ack wins and is not an overrun.
            if (wr_start && sel == A_MBX) begin
                mbx_in_data  <= OTG_DATA;
                mbx_in_valid <= 1'b1;
                if (mbx_in_valid && !mbx_in_ack)
                    ovr <= 1'b1;
            end
            if (rd_end && rd_sel == A_MBX)
                int_q <= 1'b0;
            if (mbx_out_wr) begin
                mbx_out <= mbx_out_data;
                int_q   <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk)
        if (inc_w && !soft_rst)
            mem[idx] <= OTG_DATA;

`ifdef HPI_PROTO_CHECK_EN
    logic       both_prev, wr_busy, wr_flag, addr_bad, err_ev;
    logic [1:0] wr_addr_q;
    logic [7:0] err_q;

    // A write is flagged at most once, on the first address change while it is held.
    assign addr_bad = wr_busy & wr_act & ~wr_flag & (otg.OTG_ADDR != wr_addr_q);
    assign err_ev   = (~otg.OTG_CS_N & ~otg.OTG_RD_N & ~otg.OTG_WR_N & ~both_prev) | addr_bad;
    assign proto_err_cnt = err_q;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            both_prev <= 1'b0;
            wr_busy   <= 1'b0;
            wr_flag   <= 1'b0;
            wr_addr_q <= '0;
            err_q     <= '0;
        end else if (soft_rst) begin
            both_prev <= 1'b0;
            wr_busy   <= 1'b0;
            wr_flag   <= 1'b0;
            wr_addr_q <= '0;
            err_q     <= '0;
        end else begin
            both_prev <= ~otg.OTG_CS_N & ~otg.OTG_RD_N & ~otg.OTG_WR_N;
            wr_busy   <= wr_start | (wr_busy & wr_act);
            wr_flag   <= wr_start ? 1'b0 : wr_flag | addr_bad;
            if (wr_start)
                wr_addr_q <= otg.OTG_ADDR;
            if (err_ev && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end
`else
    assign proto_err_cnt = 8'd0;
`endif
endmodule
